fft_frame_sender: RTL

//  AXI-Stream transmitter feeding the FFT core's s_axis_data slave port. Collects

---
 rtl/fft_stream_pkg.sv | 17 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fft_frame_sender.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and helpers for the FFT input streaming path.
package fft_stream_pkg;

   localparam int FFT_TDATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      FLUSH
   } state_t;

   // Builds one complex FFT input word from a 16-bit real sample; imaginary half is zero.
   function automatic logic [FFT_TDATA_W-1:0] pack_real(input logic signed [15:0] sample);
      return {16'h0000, sample};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: rd_data always shows the head entry while not empty.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   // A read on a full FIFO frees a slot in the same cycle, so a concurrent write is still accepted.
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_wr && !clear) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy tracking; clear discards everything, including a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fft_frame_sender.sv
// Buffers strobed audio samples and streams them to the FFT as fixed-length AXI-Stream frames.
module fft_frame_sender
   import fft_stream_pkg::*;
#(
   parameter int SAMPLE_W   = 16,
   parameter int FFT_SIZE   = 1024,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   enable_in,
   input  logic [SAMPLE_W-1:0]    sample_in,
   input  logic                   sample_valid_in,
   output logic [FFT_TDATA_W-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic                   frame_done_out,
   output logic                   overflow_out,
   output logic                   busy_out
);

   localparam int            CW        = $clog2(FFT_SIZE);
   localparam logic [CW-1:0] LAST_BEAT = CW'(FFT_SIZE - 1);

   state_t                 state;
   state_t                 next_state;
   logic [CW-1:0]          beat_cnt;
   logic                   out_valid;
   logic [FFT_TDATA_W-1:0] out_data;
   logic                   overflow;

   logic                   fifo_wr;
   logic                   fifo_rd;
   logic                   fifo_clear;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [SAMPLE_W-1:0]    fifo_rd_data;
   logic signed [15:0]     head_ext;

   logic                   xfer;
   logic                   last_beat;
   logic                   last_xfer;
   logic                   load_slot;
   logic                   load_valid;
   logic [FFT_TDATA_W-1:0] load_data;
   logic                   overflow_set;

   assign head_ext  = 16'(signed'(fifo_rd_data));
   assign xfer      = out_valid && m_axis_tready;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign last_xfer = xfer && last_beat;
   assign load_slot = !out_valid || xfer;

   // Samples are only accepted while streaming; in IDLE and FLUSH they are dropped silently.
   assign fifo_wr      = (state == SEND) && sample_valid_in;
   assign fifo_clear   = (state != IDLE) && (next_state == IDLE);
   assign overflow_set = fifo_wr && fifo_full && !fifo_rd && !fifo_clear;

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_in),
      .rst     (rst_in),
      .clear   (fifo_clear),
      .wr_en   (fifo_wr),
      .wr_data (sample_in),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Next-state selection followed by the decision of what the output register loads next.
   // Dropping enable before any beat of a frame exists returns straight to IDLE; once a beat
   // is pending or sent, the frame is completed through FLUSH so it is never cut short.
   always_comb begin
      next_state = state;
      fifo_rd    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;

      case (state)
         IDLE: begin
            if (enable_in) begin
               next_state = SEND;
            end
         end
         SEND: begin
            if (last_xfer) begin
               next_state = enable_in ? SEND : IDLE;
            end else if (!enable_in) begin
               next_state = (beat_cnt == '0 && !out_valid) ? IDLE : FLUSH;
            end
         end
         FLUSH: begin
            if (last_xfer) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      if (load_slot && next_state != IDLE) begin
         case (state)
            SEND: begin
               if (!fifo_empty) begin
                  fifo_rd    = 1'b1;
                  load_valid = 1'b1;
                  load_data  = pack_real(head_ext);
               end
            end
            FLUSH: begin
               load_valid = 1'b1;
               if (!fifo_empty) begin
                  fifo_rd   = 1'b1;
                  load_data = pack_real(head_ext);
               end
            end
            default: begin
               load_valid = 1'b0;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Output beat register, beat counter and sticky overflow flag; a held beat stays put until taken.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (xfer) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         end
         if (next_state == IDLE) begin
            out_valid <= 1'b0;
            out_data  <= '0;
         end else if (load_slot) begin
            out_valid <= load_valid;
            out_data  <= load_data;
         end
         if (overflow_set) begin
            overflow <= 1'b1;
         end
      end
   end

   assign m_axis_tdata   = out_data;
   assign m_axis_tvalid  = out_valid;
   assign m_axis_tlast   = out_valid && last_beat;
   assign frame_done_out = last_xfer;
   assign overflow_out   = overflow;
   assign busy_out       = (state != IDLE);

endmodule
